// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with valid/ready handshake, flush and optional skid buffer
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 3,
    parameter int SKID   = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);
    logic              w_valid;
    logic              w_in;
    logic              w_out;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    assign w_in    = valid_i & ready_o;
    assign w_out   = w_valid & ready_i;
    assign valid_o = w_valid;
    assign data_o  = r_data;
    // a bubble must never present write enables downstream
    assign ctrl_o  = w_valid ? r_ctrl : '0;

    generate
        if (SKID == 0) begin : g_single
            logic r_valid;
            assign w_valid = r_valid;
            assign ready_o = ~flush_i & (ready_i | ~r_valid);
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_ctrl  <= '0;
                end else if (flush_i) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                end else if (w_in) begin
                    r_valid <= 1'b1;
                    r_data  <= data_i;
                    r_ctrl  <= ctrl_i;
                end else if (w_out) begin
                    r_valid <= 1'b0;
                end
            end
        end else begin : g_skid
            typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
            state_t            r_state;
            state_t            w_next;
            logic              w_load_main;
            logic              w_load_skid;
            logic              w_pop_skid;
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;
            assign w_valid = (r_state != EMPTY);
            // ready depends only on state, so no path from ready_i to ready_o
            assign ready_o = ~flush_i & (r_state != FULL);
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_state <= EMPTY;
                end else begin
                    r_state <= w_next;
                end
            end
            always_comb begin
                w_next      = r_state;
                w_load_main = 1'b0;
                w_load_skid = 1'b0;
                w_pop_skid  = 1'b0;
                case (r_state)
                    EMPTY: begin
                        if (w_in) begin
                            w_next      = ONE;
                            w_load_main = 1'b1;
                        end
                    end
                    ONE: begin
                        if (w_in) begin
                            w_load_main = w_out;
                            w_load_skid = ~w_out;
                            w_next      = w_out ? ONE : FULL;
                        end else if (w_out) begin
                            w_next = EMPTY;
                        end
                    end
                    FULL: begin
                        if (w_out) begin
                            w_next     = ONE;
                            w_pop_skid = 1'b1;
                        end
                    end
                    default: w_next = EMPTY;
                endcase
                if (flush_i) w_next = EMPTY;
            end
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_data      <= '0;
                    r_ctrl      <= '0;
                    r_skid_data <= '0;
                    r_skid_ctrl <= '0;
                end else if (flush_i) begin
                    r_ctrl      <= '0;
                    r_skid_ctrl <= '0;
                end else if (w_load_main) begin
                    r_data <= data_i;
                    r_ctrl <= ctrl_i;
                end else if (w_load_skid) begin
                    r_skid_data <= data_i;
                    r_skid_ctrl <= ctrl_i;
                end else if (w_pop_skid) begin
                    r_data      <= r_skid_data;
                    r_ctrl      <= r_skid_ctrl;
                    r_skid_data <= '0;
                    r_skid_ctrl <= '0;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized scoreboard bench over four stage configurations
module tb_pipe_stage_reg;
    localparam int DW [4] = '{64, 64, 256, 1};
    localparam int CW [4] = '{3, 3, 32, 1};
    localparam int SK [4] = '{0, 1, 1, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic         vin [4];
    logic         rin [4];
    logic         fl  [4];
    logic [255:0] din [4];
    logic [31:0]  cin [4];
    wire  [255:0] dout [4];
    wire  [31:0]  cout [4];
    wire          vo [4];
    wire          ro [4];
    wire  [63:0]  d0_data, d1_data;
    wire  [2:0]   d0_ctrl, d1_ctrl;
    wire  [255:0] d2_data;
    wire  [31:0]  d2_ctrl;
    wire          d3_data, d3_ctrl;

    logic [255:0] qd [4][$];
    logic [31:0]  qc [4][$];
    int tests = 0;
    int fails = 0;
    int n_m;
    logic exp_r;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(3), .SKID(0)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(fl[0]), .valid_i(vin[0]), .ready_o(ro[0]),
        .data_i(din[0][63:0]), .ctrl_i(cin[0][2:0]), .valid_o(vo[0]), .ready_i(rin[0]),
        .data_o(d0_data), .ctrl_o(d0_ctrl));
    pipe_stage_reg #(.DATA_W(64), .CTRL_W(3), .SKID(1)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(fl[1]), .valid_i(vin[1]), .ready_o(ro[1]),
        .data_i(din[1][63:0]), .ctrl_i(cin[1][2:0]), .valid_o(vo[1]), .ready_i(rin[1]),
        .data_o(d1_data), .ctrl_o(d1_ctrl));
    pipe_stage_reg #(.DATA_W(256), .CTRL_W(32), .SKID(1)) u2 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(fl[2]), .valid_i(vin[2]), .ready_o(ro[2]),
        .data_i(din[2]), .ctrl_i(cin[2]), .valid_o(vo[2]), .ready_i(rin[2]),
        .data_o(d2_data), .ctrl_o(d2_ctrl));
    pipe_stage_reg #(.DATA_W(1), .CTRL_W(1), .SKID(0)) u3 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(fl[3]), .valid_i(vin[3]), .ready_o(ro[3]),
        .data_i(din[3][0]), .ctrl_i(cin[3][0]), .valid_o(vo[3]), .ready_i(rin[3]),
        .data_o(d3_data), .ctrl_o(d3_ctrl));

    assign dout[0] = {192'b0, d0_data};
    assign dout[1] = {192'b0, d1_data};
    assign dout[2] = d2_data;
    assign dout[3] = {255'b0, d3_data};
    assign cout[0] = {29'b0, d0_ctrl};
    assign cout[1] = {29'b0, d1_ctrl};
    assign cout[2] = d2_ctrl;
    assign cout[3] = {31'b0, d3_ctrl};

    function automatic logic [255:0] dmask(input int i);
        return (DW[i] == 256) ? '1 : ((256'd1 << DW[i]) - 256'd1);
    endfunction

    function automatic logic [31:0] cmask(input int i);
        return (CW[i] == 32) ? '1 : ((32'd1 << CW[i]) - 32'd1);
    endfunction

    task automatic chk(input string nm, input int i, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s inst%0d got=%0h exp=%0h", nm, i, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: occupancy, handshake and head-of-queue contents, then retire transfers
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                n_m = qd[i].size();
                exp_r = fl[i] ? 1'b0 : (SK[i] != 0) ? (n_m < 2) : (rin[i] | (n_m == 0));
                chk("valid_o", i, 256'(vo[i]), 256'(n_m > 0));
                chk("ready_o", i, 256'(ro[i]), 256'(exp_r));
                if (n_m > 0) begin
                    chk("data_o", i, dout[i], qd[i][0]);
                    chk("ctrl_o", i, 256'(cout[i]), 256'(qc[i][0]));
                    if (rin[i]) begin
                        void'(qd[i].pop_front());
                        void'(qc[i].pop_front());
                    end
                end else begin
                    chk("ctrl_bubble", i, 256'(cout[i]), 256'd0);
                end
                if (fl[i]) begin
                    qd[i].delete();
                    qc[i].delete();
                end
            end
        end
    end

    // Stimulus side of the scoreboard: every accepted entry is expected later, in order
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (vin[i] && ro[i]) begin
                    qd[i].push_back(din[i] & dmask(i));
                    qc[i].push_back(cin[i] & cmask(i));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            vin[i] = 1'b0; rin[i] = 1'b0; fl[i] = 1'b0; din[i] = '0; cin[i] = '0;
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_ready", i, 256'(ro[i]), 256'd1);
            chk("rst_valid", i, 256'(vo[i]), 256'd0);
            chk("rst_data", i, dout[i], 256'd0);
        end
        // asynchronous reset while holding an entry
        step;
        for (int i = 0; i < 2; i++) begin
            vin[i] = 1'b1; din[i] = 256'hDEAD; cin[i] = 32'd5;
        end
        step;
        vin[0] = 1'b0; vin[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("pre_rst_data", i, dout[i], 256'hDEAD);
            chk("pre_rst_ctrl", i, 256'(cout[i]), 256'd5);
        end
        #2 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            qd[i].delete();
            qc[i].delete();
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_rst_valid", i, 256'(vo[i]), 256'd0);
            chk("async_rst_data", i, dout[i], 256'd0);
            chk("async_rst_ctrl", i, 256'(cout[i]), 256'd0);
        end
        #2 rst_n = 1'b1;
        step;
        for (int i = 0; i < 2; i++) chk("post_rst_ready", i, 256'(ro[i]), 256'd1);
        // streaming through the plain register
        rin[0] = 1'b1; vin[0] = 1'b1; din[0] = 256'd1; cin[0] = 32'd1;
        for (int k = 1; k <= 4; k++) begin
            step;
            chk("stream_data", 0, dout[0], 256'(k));
            chk("stream_valid", 0, 256'(vo[0]), 256'd1);
            chk("stream_ready", 0, 256'(ro[0]), 256'd1);
            if (k < 4) din[0] = 256'(k + 1);
            else vin[0] = 1'b0;
        end
        rin[0] = 1'b0;
        step;
        // skid fill while stalled, then drain in order
        vin[1] = 1'b1; din[1] = 256'h11; cin[1] = 32'd1;
        step;
        din[1] = 256'h22; cin[1] = 32'd2;
        step;
        vin[1] = 1'b0;
        #1;
        chk("skid_full_ready", 1, 256'(ro[1]), 256'd0);
        chk("skid_full_data", 1, dout[1], 256'h11);
        rin[1] = 1'b1;
        step;
        chk("skid_second", 1, dout[1], 256'h22);
        chk("skid_ready_back", 1, 256'(ro[1]), 256'd1);
        step;
        chk("skid_drained", 1, 256'(vo[1]), 256'd0);
        rin[1] = 1'b0;
        // flush with a full skid stage and an offered entry
        vin[1] = 1'b1; din[1] = 256'h55; cin[1] = 32'd7;
        step;
        din[1] = 256'h66;
        step;
        din[1] = 256'h33; fl[1] = 1'b1;
        #1;
        chk("flush_ready", 1, 256'(ro[1]), 256'd0);
        step;
        vin[1] = 1'b0; fl[1] = 1'b0;
        chk("flush_valid", 1, 256'(vo[1]), 256'd0);
        chk("flush_ctrl", 1, 256'(cout[1]), 256'd0);
        chk("flush_data_kept", 1, dout[1], 256'h55);
        step;
        chk("post_flush_ready", 1, 256'(ro[1]), 256'd1);
        chk("post_flush_empty", 1, 256'(vo[1]), 256'd0);
        // simultaneous input and output transfer
        vin[0] = 1'b1; din[0] = 256'h40; cin[0] = 32'd3;
        step;
        din[0] = 256'h44; cin[0] = 32'd4; rin[0] = 1'b1;
        #1;
        chk("simul_ready", 0, 256'(ro[0]), 256'd1);
        step;
        vin[0] = 1'b0; rin[0] = 1'b0;
        chk("simul_valid", 0, 256'(vo[0]), 256'd1);
        chk("simul_data", 0, dout[0], 256'h44);
        chk("simul_ctrl", 0, 256'(cout[0]), 256'd4);
        // randomized traffic on all configurations
        for (int c = 0; c < 10000; c++) begin
            step;
            for (int i = 0; i < 4; i++) begin
                vin[i] = ($urandom_range(0, 3) != 0);
                rin[i] = $urandom_range(0, 1) == 1;
                fl[i]  = ($urandom_range(0, 31) == 0);
                for (int w = 0; w < 8; w++) din[i][w*32 +: 32] = $urandom;
                cin[i] = $urandom;
            end
        end
        step;
        for (int i = 0; i < 4; i++) begin
            vin[i] = 1'b0; fl[i] = 1'b0;
        end
        repeat (3) step;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the five-stage CPU datapath: one generic block replaces the per-stage fixed-field registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle with valid/ready flow control.
- Supports synchronous flush that turns the stage into a bubble.
- Optional one-entry skid buffer makes ready_o a registered signal, breaking the long stall path between stages.

Parameters:
DATA_W, 64, width of data bundle (e.g. ALU result + store data + rd address), 1..256
CTRL_W, 3, width of control bundle (e.g. RegWrite, MemToReg, MemWrite), 1..32
SKID, 0, 0 = single register with combinational ready_o; 1 = main + skid register with registered ready_o

Ports:
clk_i  input  1  clock, rising-edge
rst_n_i  input  1  asynchronous active-low reset
flush_i  input  1  synchronous flush: drop all held entries and insert a bubble
valid_i  input  1  upstream has an entry
ready_o  output  1  stage can accept an entry this cycle
data_i  input  DATA_W  upstream data bundle
ctrl_i  input  CTRL_W  upstream control bundle
valid_o  output  1  stage holds an entry for downstream
ready_i  input  1  downstream accepts this cycle
data_o  output  DATA_W  held data bundle
ctrl_o  output  CTRL_W  held control bundle, masked to 0 when valid_o=0

Behaviour:
- Transfers:
  - Input transfer = valid_i & ready_o at a rising edge.
  - Output transfer = valid_o & ready_i at a rising edge.
- Reset (rst_n_i=0, asynchronous):
  - valid_o=0; main data/ctrl registers = 0; skid valid/data/ctrl = 0.
  - data_o=0, ctrl_o=0.
  - ready_o: SKID=0 gives 1 (follows the formula); SKID=1 gives 1.
  - Deassertion is sampled synchronously by the state flops; no transfer occurs on the release edge if rst_n_i rises within setup.
- Latency: 1 cycle, input transfer to valid_o. Entries leave in strict arrival order. No duplication, no loss, except on flush.
- ctrl_o = ctrl_reg when valid_o=1, else all zeros (combinational mask). A bubble never asserts write enables downstream.
- data_o holds its last value when valid_o=0. It is not zeroed, except by reset.
- SKID=0:
  - ready_o = ready_i | ~valid_o (combinational), and 0 when flush_i=1.
  - On input transfer, main <= inputs and valid_o <= 1.
  - On output transfer without input transfer, valid_o <= 0.
  - Simultaneous in/out transfer: main replaced, valid_o stays 1.
- SKID=1, states EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid):
  - ready_o = ~skid_valid (registered, no combinational path from ready_i), and 0 when flush_i=1.
  - EMPTY: input -> main, go ONE.
  - ONE:
    - input & output -> main replaced, stay ONE.
    - input only -> skid loaded, go FULL.
    - output only -> go EMPTY.
  - FULL: input impossible (ready_o=0).
    - output -> skid moves to main, skid cleared, go ONE.
    - no output -> hold.
- Flush (synchronous, highest priority over all transfers):
  - At the edge where flush_i=1: valid_o <= 0, skid_valid <= 0, ctrl registers <= 0. Data registers retain their values.
  - ready_o=0 during the flush cycle, so no input transfer occurs.
  - An output transfer in the flush cycle still completes; downstream may sample it.
  - Next cycle: state EMPTY, ready_o=1.
- flush_i held for several cycles: the stage stays EMPTY with ready_o=0 throughout.
- ready_i=1 with valid_o=0 has no effect.
- valid_i=1 with ready_o=0: the upstream must hold its data stable. The stage does not capture.
- Reset mid-operation: all entries discarded immediately, whatever the state.

Test Plan:
- Reset: SKID=0 and SKID=1; assert rst_n_i=0 mid-cycle with main holding data 0xDEAD, ctrl 3'b101 -> valid_o, data_o, ctrl_o go 0 immediately without a clock edge; ready_o=1 after release.
- Streaming: SKID=0, ready_i=1, valid_i=1 with data 1,2,3,4 on consecutive cycles -> data_o = 1,2,3,4 one cycle later each, valid_o continuous, ready_o=1 throughout.
- Stall/skid: SKID=1, send A=0x11, B=0x22 back-to-back while ready_i=0 -> state FULL, ready_o=0, data_o=0x11; raise ready_i -> outputs 0x11 then 0x22 in order; ready_o returns to 1 one cycle after the first output transfer.
- Flush: SKID=1 in FULL, ctrl 3'b111; pulse flush_i with valid_i=1, data 0x33 -> next cycle valid_o=0, ctrl_o=0, data_o unchanged, 0x33 not captured; the following cycle ready_o=1.
- Simultaneous events: SKID=0 in ONE, valid_i=1 (data 0x44) and ready_i=1 in the same cycle -> old entry delivered, 0x44 captured, valid_o stays 1.
- Widths: DATA_W=1, CTRL_W=1 and DATA_W=256, CTRL_W=32 -> random valid/ready/flush, 10k cycles; a scoreboard checks order, no loss except on flush, and that ctrl_o is 0 whenever valid_o=0.
